// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - E-stage multiply/divide sequencer owning HI/LO, with busy counter and D-stage stall request
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [63:0] r_pend;
    logic        r_pend_wr;
    logic        w_done;
    logic        w_issue;

    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag;
    logic [31:0] w_quot_s, w_rem_s, w_quot_u, w_rem_u;
    logic        w_div0;

    assign w_issue = start && (r_state == S_IDLE);
    assign w_div0  = (rt_E == 32'd0);

    // Sign-extended operands give the correct low 64 bits of the signed product.
    assign w_prod_s = {{32{rs_E[31]}}, rs_E} * {{32{rt_E[31]}}, rt_E};
    assign w_prod_u = {32'd0, rs_E} * {32'd0, rt_E};

    // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
    assign w_a_mag  = rs_E[31] ? (32'd0 - rs_E) : rs_E;
    assign w_b_mag  = rt_E[31] ? (32'd0 - rt_E) : rt_E;
    assign w_b_safe = w_div0 ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_quot_s = (rs_E[31] ^ rt_E[31]) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem_s  = rs_E[31] ? (32'd0 - w_r_mag) : w_r_mag;
    assign w_quot_u = rs_E / (w_div0 ? 32'd1 : rt_E);
    assign w_rem_u  = rs_E % (w_div0 ? 32'd1 : rt_E);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (md_op == 3'd1 || md_op == 3'd2)) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = MULT_LD;
                end else if (start && (md_op == 3'd3 || md_op == 3'd4)) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = DIV_LD;
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_pend    <= 64'd0;
            r_pend_wr <= 1'b0;
            HI        <= 32'd0;
            LO        <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_issue) begin
                case (md_op)
                    3'd1: begin r_pend <= w_prod_s;             r_pend_wr <= 1'b1;    end
                    3'd2: begin r_pend <= w_prod_u;             r_pend_wr <= 1'b1;    end
                    3'd3: begin r_pend <= {w_rem_s, w_quot_s};  r_pend_wr <= !w_div0; end
                    3'd4: begin r_pend <= {w_rem_u, w_quot_u};  r_pend_wr <= !w_div0; end
                    3'd5: HI <= rs_E;
                    3'd6: LO <= rs_E;
                    default: ;
                endcase
            end
            if (w_done && r_pend_wr) begin
                HI <= r_pend[63:32];
                LO <= r_pend[31:0];
            end
        end
    end

    assign busy  = (r_state == S_RUN);
    assign stall = md_use_D && (busy || (start && md_op >= 3'd1 && md_op <= 3'd6));
endmodule
